// File: rtl/alu_issue_ctrl_if.sv
// Issue-controller bus: decode request, ALU drive/return, write-back and CPSR flag access.
// master = environment (decode, ALU, register file); slave = alu_issue_ctrl.
interface alu_issue_ctrl_if #(
    parameter int unsigned RD_W = 4
);
    logic            req_valid;
    logic            req_ready;
    logic [4:0]      req_op;
    logic [3:0]      req_cond;
    logic            req_s;
    logic [RD_W-1:0] req_rd;
    logic [31:0]     req_a;
    logic [31:0]     req_b;
    logic            req_shcout;

    logic [4:0]      alu_op;
    logic [31:0]     alu_a;
    logic [31:0]     alu_b;
    logic            alu_cin;
    logic [31:0]     alu_r;
    logic [3:0]      alu_flag;

    logic            wb_valid;
    logic            wb_we;
    logic            wb_skip;
    logic [RD_W-1:0] wb_rd;
    logic [31:0]     wb_data;

    logic            flag_wr;
    logic [3:0]      flag_wdata;
    logic [3:0]      flags;

    modport master (
        output req_valid, req_op, req_cond, req_s, req_rd, req_a, req_b, req_shcout,
        input  req_ready,
        input  alu_op, alu_a, alu_b, alu_cin,
        output alu_r, alu_flag,
        input  wb_valid, wb_we, wb_skip, wb_rd, wb_data,
        output flag_wr, flag_wdata,
        input  flags
    );

    modport slave (
        input  req_valid, req_op, req_cond, req_s, req_rd, req_a, req_b, req_shcout,
        output req_ready,
        output alu_op, alu_a, alu_b, alu_cin,
        input  alu_r, alu_flag,
        output wb_valid, wb_we, wb_skip, wb_rd, wb_data,
        input  flag_wr, flag_wdata,
        output flags
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Sequences one data-processing instruction at a time through the ALU and owns the CPSR flags.
// Define ALU_COND_EVAL_EN to enable ARM condition-code evaluation (otherwise all ops run as AL).
module alu_issue_ctrl #(
    parameter logic [3:0]  FLAG_RST = 4'b0000,
    parameter int unsigned RD_W     = 4
) (
    input logic         clk,
    input logic         reset,
    alu_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StCond, StExec, StWb} state_e;

    state_e          state_q, state_d;
    logic [4:0]      op_q;
    logic            s_q;
    logic [RD_W-1:0] rd_q;
    logic [31:0]     a_q, b_q;
    logic            shcout_q;
    logic            skip_q;
    logic [31:0]     r_q;
    logic [3:0]      flag_res_q;
    logic [3:0]      flags_q, flags_d;
    logic            cond_ok;
    logic            is_cmp;
    logic            is_arith;
    logic            accept;

`ifdef ALU_COND_EVAL_EN
    logic [3:0] cond_q;

    // flags are {C,Z,V,N}
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic c, z, v, n;
        {c, z, v, n} = f;
        unique case (cond)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = !z;
            4'h2:    cond_pass = c;
            4'h3:    cond_pass = !c;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = !n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = !v;
            4'h8:    cond_pass = c && !z;
            4'h9:    cond_pass = !c || z;
            4'ha:    cond_pass = (n == v);
            4'hb:    cond_pass = (n != v);
            4'hc:    cond_pass = !z && (n == v);
            4'hd:    cond_pass = z || (n != v);
            4'he:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    // Address ops (1xxxx) bypass the condition check.
    assign cond_ok     = op_q[4] | cond_pass(cond_q, flags_q);
    assign bus.wb_skip = (state_q == StWb) & skip_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cond_q <= 4'he;
        end else if (accept) begin
            cond_q <= bus.req_cond;
        end
    end
`else
    assign cond_ok     = 1'b1;
    assign bus.wb_skip = 1'b0;
`endif

    assign accept   = (state_q == StIdle) & bus.req_valid;
    assign is_cmp   = (op_q[4:2] == 3'b010);
    assign is_arith = (op_q[3:1] inside {3'd1, 3'd2, 3'd3, 3'd5});

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.req_valid) state_d = StCond;
            StCond:  state_d = cond_ok ? StExec : StWb;
            StExec:  state_d = StWb;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if (state_q == StWb && !skip_q && !op_q[4] && (s_q || is_cmp)) begin
            if (is_arith) begin
                flags_d = flag_res_q;
            end else begin
                // Logical ops: C from the shifter, V preserved.
                flags_d = {shcout_q, flag_res_q[2], flags_q[1], flag_res_q[0]};
            end
        end
        if (bus.flag_wr) begin
            flags_d = bus.flag_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            op_q       <= 5'b10000;
            s_q        <= 1'b0;
            rd_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            shcout_q   <= 1'b0;
            skip_q     <= 1'b0;
            r_q        <= '0;
            flag_res_q <= '0;
            flags_q    <= FLAG_RST;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            if (accept) begin
                op_q     <= bus.req_op;
                s_q      <= bus.req_s;
                rd_q     <= bus.req_rd;
                a_q      <= bus.req_a;
                b_q      <= bus.req_b;
                shcout_q <= bus.req_shcout;
            end
            if (state_q == StCond) begin
                skip_q <= !cond_ok;
            end
            if (state_q == StExec) begin
                r_q        <= bus.alu_r;
                flag_res_q <= bus.alu_flag;
            end
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.alu_op    = op_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_cin   = flags_q[3];
    assign bus.wb_valid  = (state_q == StWb);
    assign bus.wb_we     = (state_q == StWb) & !skip_q & !is_cmp;
    assign bus.wb_rd     = rd_q;
    assign bus.wb_data   = r_q;
    assign bus.flags     = flags_q;
endmodule
